// File: rtl/traffic_input_conditioner.sv
// Board-clock front end for the traffic-light controller: 1-second tick divider,
// two-flop synchronized + debounced buttons, and a latched pedestrian walk request.
module tic_debounce #(
    parameter int DEB = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic stable
);
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            // any return to the accepted level restarts the qualification window
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module traffic_input_conditioner #(
    parameter int DIV = 50000000,
    parameter int DEB = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic WalkBtn,
    input  logic ModeBtn,
    input  logic WalkAck,
    output logic TICK,
    output logic WalkReq,
    output logic ModeLvl,
    output logic ModeRise
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, PEND, HOLD} walk_st_t;

    logic [DW-1:0] div_cnt;
    logic          wlvl, wlvl_d, mlvl, mlvl_d, wrise;
    walk_st_t      st;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            TICK    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
            TICK    <= (div_cnt == DIV_MAX);
        end
    end

    tic_debounce #(.DEB(DEB)) u_walk_deb (.CLK(CLK), .RST(RST), .btn(WalkBtn), .stable(wlvl));
    tic_debounce #(.DEB(DEB)) u_mode_deb (.CLK(CLK), .RST(RST), .btn(ModeBtn), .stable(mlvl));

    assign ModeLvl = mlvl;
    assign wrise   = wlvl & ~wlvl_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wlvl_d   <= 1'b0;
            mlvl_d   <= 1'b0;
            ModeRise <= 1'b0;
        end else begin
            wlvl_d   <= wlvl;
            mlvl_d   <= mlvl;
            ModeRise <= mlvl & ~mlvl_d;
        end
    end

    // HOLD waits for release so a held button yields exactly one request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st      <= IDLE;
            WalkReq <= 1'b0;
        end else begin
            case (st)
                IDLE: if (wrise) begin
                    st      <= PEND;
                    WalkReq <= 1'b1;
                end
                PEND: if (WalkAck) begin
                    st      <= HOLD;
                    WalkReq <= 1'b0;
                end
                HOLD: if (!wlvl) st <= IDLE;
                default: begin
                    st      <= IDLE;
                    WalkReq <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner with DIV=10, DEB=4.
module tb_traffic_input_conditioner;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic WalkBtn = 1'b0, ModeBtn = 1'b0, WalkAck = 1'b0;
    logic TICK, WalkReq, ModeLvl, ModeRise;

    int n_chk = 0;
    int n_fail = 0;

    traffic_input_conditioner #(.DIV(10), .DEB(4)) dut (
        .CLK(CLK), .RST(RST), .WalkBtn(WalkBtn), .ModeBtn(ModeBtn), .WalkAck(WalkAck),
        .TICK(TICK), .WalkReq(WalkReq), .ModeLvl(ModeLvl), .ModeRise(ModeRise)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        step(2);
        chk("reset_tick", TICK, 0);
        chk("reset_walkreq", WalkReq, 0);
        chk("reset_modelvl", ModeLvl, 0);
        chk("reset_moderise", ModeRise, 0);

        // 1: divider period
        RST = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            step();
            chk($sformatf("tick_c%0d", k), TICK, (k % 10 == 0) ? 1 : 0);
        end

        // 2: bounce rejection
        for (int r = 0; r < 3; r++) begin
            WalkBtn = 1'b1;
            step(); chk("bounce_hi1", WalkReq, 0);
            step(); chk("bounce_hi2", WalkReq, 0);
            WalkBtn = 1'b0;
            step(); chk("bounce_lo", WalkReq, 0);
        end
        WalkBtn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("walk_rise_c%0d", k), WalkReq, (k == 7) ? 1 : 0);
        end
        step(3);
        chk("walk_still_pend", WalkReq, 1);

        // 3: ack while held, then release
        WalkAck = 1'b1;
        step();
        WalkAck = 1'b0;
        chk("ack_drop", WalkReq, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("hold_low", WalkReq, 0);
        end
        WalkBtn = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("release_low", WalkReq, 0);
        end

        // 4: second clean press
        WalkBtn = 1'b1;
        step(6); chk("press2_c6", WalkReq, 0);
        step();  chk("press2_c7", WalkReq, 1);

        // 5: mode button
        ModeBtn = 1'b1;
        step(5); chk("mode_c5", ModeLvl, 0);
        step();  chk("mode_c6", ModeLvl, 1);
        chk("moderise_c6", ModeRise, 0);
        step();  chk("moderise_c7", ModeRise, 1);
        step();  chk("moderise_c8", ModeRise, 0);
        step(2);
        ModeBtn = 1'b0;
        step(5); chk("mode_fall_c5", ModeLvl, 1);
        chk("moderise_fall", ModeRise, 0);
        step();  chk("mode_fall_c6", ModeLvl, 0);

        // 6: asynchronous reset with walk pending and mode high
        ModeBtn = 1'b1;
        step(7);
        chk("pre_rst_walkreq", WalkReq, 1);
        chk("pre_rst_modelvl", ModeLvl, 1);
        #2 RST = 1'b1;
        #1;
        chk("async_walkreq", WalkReq, 0);
        chk("async_tick", TICK, 0);
        chk("async_modelvl", ModeLvl, 0);
        chk("async_moderise", ModeRise, 0);
        step(2);
        RST = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("rst_tick_c%0d", k), TICK, (k == 10) ? 1 : 0);
            chk($sformatf("rst_walk_c%0d", k), WalkReq, (k >= 7) ? 1 : 0);
            chk($sformatf("rst_mode_c%0d", k), ModeLvl, (k >= 6) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
